// File: rtl/restador_serie_param.sv
// Bit-serial WIDTH-bit subtractor R = X - Y - BI, LSB first, one full-subtractor cell per clock.
// Optional signed-overflow output OV is built when RESTADOR_OVF_EN is defined.
module restador_serie_param #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             BI,
  output logic [WIDTH-1:0] R,
  output logic             AN,
  output logic             busy,
  output logic             done,
`ifdef RESTADOR_OVF_EN
  output logic             OV,
`endif
  output logic [1:0]       fsm_state
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Handshake: start is accepted on a rising edge while state is IDLE or DONE;
  // done is a one-cycle pulse in DONE, busy is high throughout SHIFT.
  logic [1:0]       state;
  logic [WIDTH-1:0] sx, sy, sr;
  logic             b;
  logic [CW-1:0]    count;
  logic             d, b_next;
  logic [WIDTH-1:0] sr_next;
`ifdef RESTADOR_OVF_EN
  logic             x_msb, y_msb;
`endif

  always_comb begin
    d       = sx[0] ^ sy[0] ^ b;
    b_next  = (~sx[0] & sy[0]) | (~(sx[0] ^ sy[0]) & b);
    sr_next = {d, sr[WIDTH-1:1]};
  end

  assign busy      = (state == SHIFT);
  assign done      = (state == DONE);
  assign fsm_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sx    <= '0;
      sy    <= '0;
      sr    <= '0;
      b     <= 1'b0;
      count <= '0;
      R     <= '0;
      AN    <= 1'b0;
`ifdef RESTADOR_OVF_EN
      x_msb <= 1'b0;
      y_msb <= 1'b0;
      OV    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            sx    <= X;
            sy    <= Y;
            b     <= BI;
            sr    <= '0;
            count <= '0;
`ifdef RESTADOR_OVF_EN
            x_msb <= X[WIDTH-1];
            y_msb <= Y[WIDTH-1];
`endif
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          sx    <= sx >> 1;
          sy    <= sy >> 1;
          b     <= b_next;
          sr    <= sr_next;
          count <= count + 1'b1;
          // The last bit is folded straight into R so intermediate sr is never exposed.
          if (count == LAST) begin
            R     <= sr_next;
            AN    <= b_next;
            count <= '0;
`ifdef RESTADOR_OVF_EN
            OV    <= (x_msb != y_msb) && (sr_next[WIDTH-1] != x_msb);
`endif
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_restador_serie_param.sv
// Bench for restador_serie_param (WIDTH=8): directed vectors, expected results queued at
// acceptance and checked by an independent monitor on every done pulse.
module tb_restador_serie_param;

  localparam int W = 8;
  localparam int LAT = W;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] X, Y;
  logic         BI;
  logic [W-1:0] R;
  logic         AN, busy, done;
  logic [1:0]   fsm_state;
`ifdef RESTADOR_OVF_EN
  logic         OV;
`endif

  restador_serie_param #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .X(X), .Y(Y), .BI(BI),
    .R(R), .AN(AN), .busy(busy), .done(done),
`ifdef RESTADOR_OVF_EN
    .OV(OV),
`endif
    .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_seen = 0;
  logic prev_done = 1'b0;

  // Entry layout: {ov, an, r}
  logic [W+1:0] exp_q[$];
  int           acc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (!rst) begin
      check("busy_done_exclusive", {63'd0, busy & done}, 64'd0);
      if (done) begin
        logic [W+1:0] e;
        int a;
        done_seen++;
        check("done_single_cycle", {63'd0, prev_done}, 64'd0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          check("result_R", 64'(R), 64'(e[W-1:0]));
          check("result_AN", 64'(AN), 64'(e[W]));
          check("latency", 64'(cyc - a), 64'(LAT));
`ifdef RESTADOR_OVF_EN
          check("result_OV", 64'(OV), 64'(e[W+1]));
`endif
        end
      end
      prev_done <= done;
    end else begin
      prev_done <= 1'b0;
    end
  end

  // Drives one request (DUT must be IDLE or DONE) and queues its expected result.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi,
                       input logic [W-1:0] er, input logic ean, input logic eov);
    X = x; Y = y; BI = bi; start = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back({eov, ean, er});
    acc_q.push_back(cyc);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input logic check_busy);
    int nb = 0;
    logic got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
      if (busy) nb++;
    end
    check({name, "_done_seen"}, {63'd0, got}, 64'd1);
    if (check_busy) check({name, "_busy_cycles"}, 64'(nb), 64'(LAT));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; X = '0; Y = '0; BI = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_R", 64'(R), 64'd0);
    check("reset_AN", 64'(AN), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    issue(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    wait_done("op_05_03", 1'b1);
    issue(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
    wait_done("op_03_05", 1'b1);
    issue(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    wait_done("op_00_00_bi", 1'b1);
    @(negedge clk);

    // start held high: accepted every W+1 edges
    X = 8'h10; Y = 8'h01; BI = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back({1'b0, 1'b0, 8'h0F}); acc_q.push_back(cyc);
    for (int k = 0; k < 2; k++) begin
      repeat (LAT + 1) @(posedge clk);
      #1;
      exp_q.push_back({1'b0, 1'b0, 8'h0F}); acc_q.push_back(cyc);
    end
    start = 1'b0;
    wait_done("b2b_last", 1'b1);
    @(negedge clk);
    check("b2b_done_count", 64'(done_seen), 64'd6);

    // start while busy is ignored
    issue(8'h20, 8'h01, 1'b0, 8'h1F, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    X = 8'hFF; Y = 8'h00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("ignored_start", 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("no_extra_op_busy", 64'(busy), 64'd0);

    // reset mid-operation aborts it
    issue(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    void'(exp_q.pop_back());
    void'(acc_q.pop_back());
    check("abort_R", 64'(R), 64'd0);
    check("abort_AN", 64'(AN), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_no_done", 64'(done_seen), 64'd7);

    issue(8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1);
    wait_done("op_7F_80", 1'b1);
    issue(8'hFF, 8'hFE, 1'b1, 8'h00, 1'b0, 1'b0);
    wait_done("op_FF_FE_bi", 1'b1);
    issue(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    wait_done("op_80_01", 1'b1);
    issue(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
    wait_done("op_7F_FF", 1'b1);
    issue(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    wait_done("op_05_03_again", 1'b1);
    repeat (3) @(negedge clk);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/restador_serie_param.md
Name: restador_serie_param

Overview:
- Parametrised bit-serial N-bit subtractor computing R = X - Y - BI, one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow.
- Successor to the combinational 1-bit half subtractor: generalised in width, adds borrow-in, and adds a start/busy/done handshake.
- Sits in the arithmetic datapath wherever area matters more than latency.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..64.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- X  input  WIDTH  minuend; captured on the accepting edge.
- Y  input  WIDTH  subtrahend; captured on the accepting edge.
- BI  input  1  borrow-in; captured on the accepting edge.
- R  output  WIDTH  difference; registered; holds until the next completion.
- AN  output  1  borrow-out (1 = unsigned X < Y + BI); registered; holds.
- busy  output  1  high while bits are being processed.
- done  output  1  single-cycle completion pulse.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-high; no synchronous clear exists.
- Reset values: R=0, AN=0, busy=0, done=0, state=IDLE, count=0, internal shift registers and borrow register = 0.
- States:
  - IDLE: start=1 loads X into shift register sx, Y into sy, BI into borrow register b, and clears count; next state is SHIFT.
  - SHIFT: busy=1. Each edge:
    - d = sx[0]^sy[0]^b
    - b <= (~sx[0]&sy[0]) | (~(sx[0]^sy[0])&b)
    - d shifts into the MSB of the result shift register sr
    - sx and sy shift right
    - count increments
  - SHIFT exit: on the edge where count reaches WIDTH-1, R <= final sr contents, AN <= final borrow, and next state is DONE.
- DONE: done=1 for exactly one cycle.
  - start=1 in DONE is accepted exactly as in IDLE: back-to-back operation, with no idle cycle required.
  - Otherwise the next state is IDLE.
- Latency: start sampled at edge k gives R/AN updated at edge k+WIDTH, and done high from edge k+WIDTH to edge k+WIDTH+1. Throughput is one result per WIDTH+1 cycles when back-to-back.
- Arithmetic: modulo 2^WIDTH; AN equals bit WIDTH of the (WIDTH+1)-bit result of X - Y - BI.
- start while busy=1 is ignored; no queueing, and X/Y/BI changes during SHIFT have no effect.
- R/AN change only at completion. Intermediate bits are never visible on R.
- Reset asserted mid-operation aborts immediately and restores all reset values; no done pulse is produced.
- busy and done are never high simultaneously. Counter width is $clog2(WIDTH).

Optional Feature:
- Macro: RESTADOR_OVF_EN.
- Defined: adds output OV (1 bit, reset 0), the signed two's-complement overflow. It is set when X[MSB] != Y[MSB] and R[MSB] != X[MSB], and is registered with R at completion.
- Undefined: OV port and logic are absent; all other behaviour is identical.

Test Plan (WIDTH=8):
- X=0x05, Y=0x03, BI=0, start pulse -> done exactly 8 edges after acceptance; R=0x02, AN=0; busy high for 8 cycles.
- X=0x03, Y=0x05, BI=0 -> R=0xFE, AN=1. Then X=0x00, Y=0x00, BI=1 -> R=0xFF, AN=1.
- start held high continuously with X=0x10, Y=0x01 -> results every 9 cycles; R=0x0F, AN=0; done pulses 1 cycle each.
- Operation 0x20-0x01 running; at cycle 3 drive X=0xFF, Y=0x00, start=1 -> ignored; result R=0x1F.
- rst asserted at cycle 4 of an operation -> R=0, AN=0, busy=0 immediately, no done; a fresh start afterwards completes normally.
- RESTADOR_OVF_EN: 0x80-0x01 -> R=0x7F, OV=1; 0x7F-0xFF -> R=0x80, OV=1; 0x05-0x03 -> OV=0.
